// File: rtl/deser_32.sv
// 32-bit serial-to-parallel receiver with selectable bit order, a single-word
// output buffer, valid/ack handshake and a sticky overrun flag.
module deser_32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enb,
    input  logic        dir,
    input  logic        start,
    input  logic        s_in,
    input  logic        ack,
    output logic [31:0] Q,
    output logic        valid,
    output logic        busy,
    output logic        overrun,
    output logic [5:0]  bit_cnt
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic [31:0] shreg_q, shreg_d;
    logic        dir_l_q, dir_l_d;
    logic [31:0] q_q, q_d;
    logic        valid_q, valid_d;
    logic        overrun_q, overrun_d;
    logic        busy_q, busy_d;
    logic        done_s;
    logic [31:0] word_s;

    // Frame sequencing: start, bit sampling, completion detection.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        dir_l_d   = dir_l_q;
        done_s    = 1'b0;
        // The latched order, not the live dir input, decides the shift.
        if (dir_l_q) begin
            word_s = {s_in, shreg_q[31:1]};
        end else begin
            word_s = {shreg_q[30:0], s_in};
        end

        if (start) begin
            // Restart wins over any sample, including a would-be final bit.
            state_d   = RECV;
            bit_cnt_d = 6'd0;
            shreg_d   = 32'd0;
            dir_l_d   = dir;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                RECV: begin
                    if (enb) begin
                        if (bit_cnt_q == 6'd31) begin
                            state_d   = IDLE;
                            bit_cnt_d = 6'd0;
                            shreg_d   = 32'd0;
                            done_s    = 1'b1;
                        end else begin
                            shreg_d   = word_s;
                            bit_cnt_d = bit_cnt_q + 6'd1;
                        end
                    end else begin
                        state_d = RECV;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    bit_cnt_d = 6'd0;
                    shreg_d   = 32'd0;
                end
            endcase
        end
        busy_d = (state_d == RECV);
    end

    // Output buffer handshake: load, drop-with-overrun, or acknowledge.
    always_comb begin
        q_d       = q_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (done_s) begin
            if (!valid_q || ack) begin
                q_d       = word_s;
                valid_d   = 1'b1;
                overrun_d = 1'b0;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && ack) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end else begin
            valid_d   = valid_q;
            overrun_d = overrun_q;
        end
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= 6'd0;
            shreg_q   <= 32'd0;
            dir_l_q   <= 1'b0;
            q_q       <= 32'd0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            dir_l_q   <= dir_l_d;
            q_q       <= q_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            busy_q    <= busy_d;
        end
    end

    assign Q       = q_q;
    assign valid   = valid_q;
    assign busy    = busy_q;
    assign overrun = overrun_q;
    assign bit_cnt = bit_cnt_q;

endmodule

// File: tb/tb_deser_32.sv
// Directed bench for deser_32: hand-computed words, handshake and reset cases.
module tb_deser_32;

    logic        clk;
    logic        rst_n;
    logic        enb;
    logic        dir;
    logic        start;
    logic        s_in;
    logic        ack;
    logic [31:0] Q;
    logic        valid;
    logic        busy;
    logic        overrun;
    logic [5:0]  bit_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    deser_32 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .enb     (enb),
        .dir     (dir),
        .start   (start),
        .s_in    (s_in),
        .ack     (ack),
        .Q       (Q),
        .valid   (valid),
        .busy    (busy),
        .overrun (overrun),
        .bit_cnt (bit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One clock with the given sample inputs; outputs settle 1 time unit later.
    task automatic tick(input logic st, input logic en, input logic b, input logic a);
        @(negedge clk);
        start = st;
        enb   = en;
        s_in  = b;
        ack   = a;
        @(posedge clk);
        #1;
        start = 1'b0;
        enb   = 1'b0;
        ack   = 1'b0;
    endtask

    task automatic start_frame(input logic d, input logic en);
        @(negedge clk);
        dir = d;
        tick(1'b1, en, 1'b0, 1'b0);
    endtask

    // Send bits [first..last] of w in transmit order for the given direction.
    task automatic send_bits(input logic [31:0] w, input logic d, input int first,
                             input int last, input logic ack_last);
        for (int i = first; i <= last; i++) begin
            tick(1'b0, 1'b1, d ? w[i] : w[31-i], (i == 31) ? ack_last : 1'b0);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input logic d, input logic ack_last);
        start_frame(d, 1'b0);
        send_bits(w, d, 0, 31, ack_last);
    endtask

    initial begin
        logic [31:0] w;
        rst_n = 1'b0; enb = 1'b0; dir = 1'b0; start = 1'b0; s_in = 1'b0; ack = 1'b0;
        #3;
        chk_eq("rst_q", Q, 32'h0);
        chk_eq("rst_valid", {31'd0, valid}, 32'd0);
        chk_eq("rst_busy", {31'd0, busy}, 32'd0);
        chk_eq("rst_cnt", {26'd0, bit_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Serial input is ignored while idle.
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        chk_eq("idle_cnt", {26'd0, bit_cnt}, 32'd0);
        chk_eq("idle_busy", {31'd0, busy}, 32'd0);

        // MSB-first word.
        w = 32'hA5A50F0F;
        start_frame(1'b0, 1'b0);
        chk_eq("start_busy", {31'd0, busy}, 32'd1);
        chk_eq("start_cnt", {26'd0, bit_cnt}, 32'd0);
        send_bits(w, 1'b0, 0, 30, 1'b0);
        chk_eq("msb_cnt31", {26'd0, bit_cnt}, 32'd31);
        chk_eq("msb_novalid", {31'd0, valid}, 32'd0);
        send_bits(w, 1'b0, 31, 31, 1'b0);
        chk_eq("msb_q", Q, 32'hA5A50F0F);
        chk_eq("msb_valid", {31'd0, valid}, 32'd1);
        chk_eq("msb_busy", {31'd0, busy}, 32'd0);
        chk_eq("msb_cnt", {26'd0, bit_cnt}, 32'd0);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        chk_eq("ack_valid", {31'd0, valid}, 32'd0);
        chk_eq("ack_q_hold", Q, 32'hA5A50F0F);

        // LSB-first word with dir toggled mid-frame.
        w = 32'h12345678;
        start_frame(1'b1, 1'b0);
        send_bits(w, 1'b1, 0, 9, 1'b0);
        dir = 1'b0;
        send_bits(w, 1'b1, 10, 31, 1'b0);
        chk_eq("lsb_q", Q, 32'h12345678);
        tick(1'b0, 1'b0, 1'b0, 1'b1);

        // Enable gaps after bits 5 and 20.
        w = 32'hDEADBEEF;
        start_frame(1'b0, 1'b0);
        send_bits(w, 1'b0, 0, 4, 1'b0);
        for (int g = 0; g < 3; g++) tick(1'b0, 1'b0, 1'b1, 1'b0);
        chk_eq("gap5_cnt", {26'd0, bit_cnt}, 32'd5);
        chk_eq("gap5_busy", {31'd0, busy}, 32'd1);
        send_bits(w, 1'b0, 5, 19, 1'b0);
        for (int g = 0; g < 3; g++) tick(1'b0, 1'b0, 1'b0, 1'b0);
        chk_eq("gap20_cnt", {26'd0, bit_cnt}, 32'd20);
        send_bits(w, 1'b0, 20, 31, 1'b0);
        chk_eq("gap_q", Q, 32'hDEADBEEF);
        tick(1'b0, 1'b0, 1'b0, 1'b1);

        // Overrun, acknowledge, and reload paths.
        send_word(32'h11111111, 1'b0, 1'b0);
        send_word(32'h22222222, 1'b0, 1'b0);
        chk_eq("ovr_q", Q, 32'h11111111);
        chk_eq("ovr_valid", {31'd0, valid}, 32'd1);
        chk_eq("ovr_flag", {31'd0, overrun}, 32'd1);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        chk_eq("ovr_ack_valid", {31'd0, valid}, 32'd0);
        chk_eq("ovr_ack_flag", {31'd0, overrun}, 32'd0);
        send_word(32'h33333333, 1'b0, 1'b1);
        chk_eq("f3_q", Q, 32'h33333333);
        chk_eq("f3_valid", {31'd0, valid}, 32'd1);
        send_word(32'h44444444, 1'b1, 1'b0);
        chk_eq("f4_drop_q", Q, 32'h33333333);
        chk_eq("f4_ovr", {31'd0, overrun}, 32'd1);
        send_word(32'h5A5A0001, 1'b0, 1'b1);
        chk_eq("reload_q", Q, 32'h5A5A0001);
        chk_eq("reload_valid", {31'd0, valid}, 32'd1);
        chk_eq("reload_ovr", {31'd0, overrun}, 32'd0);

        // Asynchronous reset mid-frame with a word still pending.
        start_frame(1'b0, 1'b0);
        send_bits(32'hFFFFFFFF, 1'b0, 0, 16, 1'b0);
        chk_eq("pre_rst_cnt", {26'd0, bit_cnt}, 32'd17);
        #2;
        rst_n = 1'b0;
        #1;
        chk_eq("arst_q", Q, 32'h0);
        chk_eq("arst_valid", {31'd0, valid}, 32'd0);
        chk_eq("arst_busy", {31'd0, busy}, 32'd0);
        chk_eq("arst_cnt", {26'd0, bit_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        chk_eq("post_rst_busy", {31'd0, busy}, 32'd0);
        chk_eq("post_rst_cnt", {26'd0, bit_cnt}, 32'd0);

        // Restart at bit 20 and at the final bit.
        start_frame(1'b0, 1'b0);
        send_bits(32'hFFFFFFFF, 1'b0, 0, 19, 1'b0);
        chk_eq("rs20_pre", {26'd0, bit_cnt}, 32'd20);
        start_frame(1'b0, 1'b1);
        chk_eq("rs20_cnt", {26'd0, bit_cnt}, 32'd0);
        chk_eq("rs20_busy", {31'd0, busy}, 32'd1);
        send_bits(32'hFFFFFFFF, 1'b0, 0, 30, 1'b0);
        start_frame(1'b0, 1'b1);
        chk_eq("rs31_cnt", {26'd0, bit_cnt}, 32'd0);
        chk_eq("rs31_valid", {31'd0, valid}, 32'd0);
        chk_eq("rs31_q", Q, 32'h0);
        send_bits(32'h0F0F0F0F, 1'b0, 0, 31, 1'b0);
        chk_eq("rs_q", Q, 32'h0F0F0F0F);
        chk_eq("rs_valid", {31'd0, valid}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/deser_32.md
DESER_32 -- requirements
Module: deser_32

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock; only clock in block.
REQ-002 SHALL have port: rst_n  input  1  reset; asynchronous, active-low.
REQ-003 SHALL have port: enb  input  1  bit-sample enable; s_in sampled only on clk edges with enb=1.
REQ-004 SHALL have port: dir  input  1  bit order; 0 = MSB first (shift left, new bit into Q bit 0 side); 1 = LSB first (shift right, new bit into bit 31 side).
REQ-005 SHALL have port: start  input  1  begin (or restart) a 32-bit frame.
REQ-006 SHALL have port: s_in  input  1  serial data bit.
REQ-007 SHALL have port: ack  input  1  consumer acknowledge of current word.
REQ-008 SHALL have port: Q  output  32  last completed received word.
REQ-009 SHALL have port: valid  output  1  Q holds an unacknowledged word.
REQ-010 SHALL have port: busy  output  1  frame reception in progress.
REQ-011 SHALL have port: overrun  output  1  sticky flag; a completed word was dropped.
REQ-012 SHALL have port: bit_cnt  output  6  bits received in current frame (0..31).

Function
REQ-013 SHALL implement FSM states IDLE and RECV; busy=1 exactly in RECV.
REQ-014 SHALL, on start=1 in any state, enter RECV next edge with bit_cnt=0, internal shift register cleared, dir latched into dir_l; no bit sampled on the start cycle.
REQ-015 SHALL ignore dir changes while in RECV; only dir_l governs shifting.
REQ-016 SHALL, in RECV with enb=1 and start=0, shift s_in into the internal register per dir_l and increment bit_cnt.
REQ-017 SHALL, in RECV with enb=0, hold shift register, bit_cnt and state.
REQ-018 SHALL, on the edge sampling the 32nd bit (bit_cnt=31, enb=1, start=0), return to IDLE with bit_cnt=0 and complete the word.
REQ-019 SHALL, on completion with valid=0, or valid=1 and ack=1 same cycle, load Q with the full word and set valid=1 (latency: Q/valid update on the same edge that samples bit 32).
REQ-020 SHALL, on completion with valid=1 and ack=0, drop the new word, keep Q unchanged, keep valid=1, set overrun=1.
REQ-021 SHALL clear valid and overrun on the edge after ack=1 while valid=1, unless REQ-019 reloads the same edge (then valid stays 1, overrun cleared).
REQ-022 SHALL ignore ack while valid=0.
REQ-023 SHALL give start priority over a simultaneous final-bit sample: partial frame discarded, no completion, restart per REQ-014.
REQ-024 SHALL hold Q unchanged except at completion per REQ-019; s_in ignored in IDLE.
REQ-025 SHALL produce, for a transmitter loading word W and shifting it out one bit per enabled clock with matching dir, Q=W after 32 enabled bits.

Reset
REQ-026 SHALL, while rst_n=0, force immediately (no clock): state IDLE, Q=0, valid=0, busy=0, overrun=0, bit_cnt=0, shift register=0, dir_l=0.
REQ-027 SHALL, on reset asserted mid-frame, discard the partial frame; first edge after release with start=0 leaves block in IDLE.

Verification
REQ-028 SHALL cover: dir=0, start, 32 enabled bits of 0xA5A50F0F MSB first -> after 32nd edge Q=0xA5A50F0F, valid=1, busy=0, bit_cnt=0.
REQ-029 SHALL cover: dir=1, start, 0x12345678 LSB first, dir toggled at bit 10 -> Q=0x12345678.
REQ-030 SHALL cover: frame 0xDEADBEEF with enb=0 for 3 cycles after bits 5 and 20 -> bit_cnt holds at 5 and 20 during gaps; Q=0xDEADBEEF after 38 clocks of RECV.
REQ-031 SHALL cover: two frames 0x11111111 then 0x22222222, no ack -> Q=0x11111111, valid=1, overrun=1; then ack -> valid=0, overrun=0; third frame with ack on its final edge -> Q loaded, valid=1.
REQ-032 SHALL cover: rst_n low at bit_cnt=17 -> all outputs 0 asynchronously, IDLE after release.
REQ-033 SHALL cover: start re-asserted at bit_cnt=20, and at bit_cnt=31 with enb=1 -> bit_cnt=0, no valid; next 32 bits 0x0F0F0F0F give Q=0x0F0F0F0F.
